// File: rtl/pcie_pkg.sv
// Shared BRAM-side types and widths for the engines that sit in front of the
// banked BRAM mux.
package pcie_pkg;

  localparam int BRAM_ADDR_W = 16;
  localparam int BRAM_DATA_W = 512;

  typedef struct packed {
    logic                   wr;
    logic [BRAM_ADDR_W-1:0] addr;
    logic [BRAM_DATA_W-1:0] wr_data;
  } bram_req_t;

  // Index width that stays legal (>=1 bit) for single-entry vectors.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first request at or after the pointer and
// moves the pointer just past the winner. Reusable by any engine.
module rr_arbiter
  import pcie_pkg::*;
#(
  parameter int NB_REQ = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NB_REQ-1:0] i_req,
  output logic [NB_REQ-1:0] o_grant
);

  localparam int PTR_W = idx_w(NB_REQ);

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_pick;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic             w_found;

  // First pass covers [ptr, NB_REQ), second pass supplies the wrap-around.
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = 0; i < NB_REQ; i++) begin
      if (!w_found && (i >= int'(r_ptr)) && i_req[i]) begin
        o_grant[i] = 1'b1;
        w_found    = 1'b1;
        w_pick     = PTR_W'(i);
      end
    end
    for (int i = 0; i < NB_REQ; i++) begin
      if (!w_found && i_req[i]) begin
        o_grant[i] = 1'b1;
        w_found    = 1'b1;
        w_pick     = PTR_W'(i);
      end
    end
  end

  assign w_ptr_nxt = (w_pick == PTR_W'(NB_REQ - 1)) ? '0 : w_pick + PTR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= w_ptr_nxt;
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// Shares one BRAM mux port between NB_REQ requesters: round-robin grant,
// registered command issue, fixed-latency read return and quiesce/idle handshake.
module bram_arbiter
  import pcie_pkg::*;
#(
  parameter int NB_REQ     = 3,
  parameter int ADDR_WIDTH = BRAM_ADDR_W,
  parameter int DATA_WIDTH = BRAM_DATA_W,
  parameter int RD_LATENCY = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NB_REQ-1:0]            req_valid,
  output logic [NB_REQ-1:0]            req_ready,
  input  logic [NB_REQ-1:0]            req_wr,
  input  logic [NB_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NB_REQ*DATA_WIDTH-1:0] req_wr_data,
  output logic [NB_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]        rsp_data,
  output logic [ADDR_WIDTH-1:0]        bram_addr,
  output logic [DATA_WIDTH-1:0]        bram_wr_data,
  output logic                         bram_rd_en,
  output logic                         bram_wr_en,
  input  logic [DATA_WIDTH-1:0]        bram_rd_data,
  input  logic                         quiesce,
  output logic                         idle
);

  localparam int ID_W = idx_w(NB_REQ);

  if (RD_LATENCY < 1) begin : g_bad_latency
    $error("bram_arbiter: RD_LATENCY must be >= 1");
  end
  if ((ADDR_WIDTH != BRAM_ADDR_W) || (DATA_WIDTH != BRAM_DATA_W)) begin : g_bad_width
    $error("bram_arbiter: widths must match the pcie_pkg BRAM widths");
  end

  logic [NB_REQ-1:0] w_cand;
  logic [NB_REQ-1:0] w_grant;
  logic              w_xfer;
  bram_req_t         w_cmd;
  logic [ID_W-1:0]   w_id;
  logic              w_tail_vld;

  bram_req_t         r_cmd;
  logic              r_issue;
  logic [ID_W-1:0]   r_id;
  logic [RD_LATENCY-1:0] r_pipe_vld;
  logic [ID_W-1:0]   r_pipe_id [RD_LATENCY];

  assign w_cand = req_valid & ~{NB_REQ{quiesce}};

  rr_arbiter #(.NB_REQ(NB_REQ)) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_req   (w_cand),
    .o_grant (w_grant)
  );

  assign req_ready = w_grant;
  assign w_xfer    = |(req_valid & w_grant);

  always_comb begin
    w_cmd = '0;
    w_id  = '0;
    for (int i = 0; i < NB_REQ; i++) begin
      if (w_grant[i]) begin
        w_cmd.wr      = req_wr[i];
        w_cmd.addr    = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_cmd.wr_data = req_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
        w_id          = ID_W'(i);
      end
    end
  end

  // Address/data only load on a transfer; they may go stale while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issue <= 1'b0;
      r_cmd   <= '0;
      r_id    <= '0;
    end else begin
      r_issue <= w_xfer;
      if (w_xfer) begin
        r_cmd <= w_cmd;
        r_id  <= w_id;
      end
    end
  end

  assign bram_rd_en   = r_issue & ~r_cmd.wr;
  assign bram_wr_en   = r_issue & r_cmd.wr;
  assign bram_addr    = r_cmd.addr;
  assign bram_wr_data = r_cmd.wr_data;

  // Return pipe: stage 0 captures the read issued this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe_vld <= '0;
      for (int s = 0; s < RD_LATENCY; s++) r_pipe_id[s] <= '0;
    end else begin
      r_pipe_vld[0] <= bram_rd_en;
      r_pipe_id[0]  <= r_id;
      for (int s = 1; s < RD_LATENCY; s++) begin
        r_pipe_vld[s] <= r_pipe_vld[s-1];
        r_pipe_id[s]  <= r_pipe_id[s-1];
      end
    end
  end

  assign w_tail_vld = r_pipe_vld[RD_LATENCY-1];

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NB_REQ; i++) begin
      if (w_tail_vld && (r_pipe_id[RD_LATENCY-1] == ID_W'(i))) rsp_valid[i] = 1'b1;
    end
  end

  assign rsp_data = w_tail_vld ? bram_rd_data : '0;

  assign idle = ~bram_rd_en & ~bram_wr_en & ~(|r_pipe_vld) & ~w_xfer;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter: a 3-requester instance plus a single-requester
// instance, each in front of a small behavioural BRAM with 4-cycle read latency.
module tb_bram_arbiter;

  localparam int NR  = 3;
  localparam int AW  = 16;
  localparam int DW  = 512;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid, req_ready, req_wr, rsp_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wr_data;
  logic [DW-1:0]    rsp_data, bram_wr_data, bram_rd_data;
  logic [AW-1:0]    bram_addr;
  logic             bram_rd_en, bram_wr_en, quiesce, idle;

  logic [0:0]       s_valid, s_ready, s_wr, s_rsp_valid;
  logic [AW-1:0]    s_addr, s_baddr;
  logic [DW-1:0]    s_wdata, s_rsp_data, s_bwdata, s_brdata;
  logic             s_rd_en, s_wr_en, s_idle;

  logic             pre_we;
  logic [7:0]       pre_addr;
  logic [DW-1:0]    pre_data;

  int n_total = 0;
  int n_bad   = 0;

  bram_arbiter #(.NB_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wr_data(req_wr_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .bram_addr(bram_addr), .bram_wr_data(bram_wr_data),
    .bram_rd_en(bram_rd_en), .bram_wr_en(bram_wr_en), .bram_rd_data(bram_rd_data),
    .quiesce(quiesce), .idle(idle)
  );

  bram_arbiter #(.NB_REQ(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(LAT)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(s_valid), .req_ready(s_ready), .req_wr(s_wr),
    .req_addr(s_addr), .req_wr_data(s_wdata),
    .rsp_valid(s_rsp_valid), .rsp_data(s_rsp_data),
    .bram_addr(s_baddr), .bram_wr_data(s_bwdata),
    .bram_rd_en(s_rd_en), .bram_wr_en(s_wr_en), .bram_rd_data(s_brdata),
    .quiesce(1'b0), .idle(s_idle)
  );

  // BRAM models: read data appears LAT cycles after the rd_en cycle.
  logic [DW-1:0] mem  [256];
  logic [DW-1:0] rp   [LAT];
  logic [DW-1:0] mem2 [16];
  logic [DW-1:0] rp2  [LAT];

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bram_wr_en) mem[bram_addr[7:0]] <= bram_wr_data;
    rp[0] <= bram_rd_en ? mem[bram_addr[7:0]] : '0;
    for (int i = 1; i < LAT; i++) rp[i] <= rp[i-1];
  end
  assign bram_rd_data = rp[LAT-1];

  always @(posedge clk) begin
    if (s_wr_en) mem2[s_baddr[3:0]] <= s_bwdata;
    rp2[0] <= s_rd_en ? mem2[s_baddr[3:0]] : '0;
    for (int i = 1; i < LAT; i++) rp2[i] <= rp2[i-1];
  end
  assign s_brdata = rp2[LAT-1];

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = 1'b1;
    req_wr[i]    = wr;
    req_addr[i*AW +: AW]    = a;
    req_wr_data[i*DW +: DW] = d;
  endtask

  task automatic clr_req();
    req_valid = '0;
    req_wr    = '0;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    quiesce = 1'b0;
    clr_req();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [DW-1:0] d);
    tick();
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ready", req_ready, '0);
    chk("rst_rsp_valid", rsp_valid, '0);
    chk("rst_rsp_data", rsp_data, '0);
    chk("rst_rd_en", bram_rd_en, 0);
    chk("rst_wr_en", bram_wr_en, 0);
    chk("rst_addr", bram_addr, '0);
    chk("rst_idle", idle, 1);
  endtask

  initial begin
    rst_n = 1'b0; quiesce = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    req_valid = '0; req_wr = '0; req_addr = '0; req_wr_data = '0;
    s_valid = '0; s_wr = '0; s_addr = '0; s_wdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    chk("rst_idle1", s_idle, 1);

    // Single read
    do_reset();
    preload(8'h10, 512'hAB);
    tick(); set_req(0, 1'b0, 16'h0010, '0);
    @(negedge clk);
    chk("t1_ready", req_ready, 3'b001);
    chk("t1_idle_busy", idle, 0);
    tick(); clr_req();
    @(negedge clk);
    chk("t1_rd_en", bram_rd_en, 1);
    chk("t1_wr_en", bram_wr_en, 0);
    chk("t1_addr", bram_addr, 16'h0010);
    for (int c = 2; c < 5; c++) begin
      tick(); @(negedge clk);
      chk("t1_no_rsp", rsp_valid, '0);
    end
    tick(); @(negedge clk);
    chk("t1_rsp_valid", rsp_valid, 3'b001);
    chk("t1_rsp_data", rsp_data, 512'hAB);
    tick(); @(negedge clk);
    chk("t1_rsp_done", rsp_valid, '0);
    chk("t1_idle", idle, 1);

    // Fairness: all three hold reads for 9 cycles
    do_reset();
    preload(8'h30, 512'hA0);
    preload(8'h31, 512'hA1);
    preload(8'h32, 512'hA2);
    for (int c = 0; c < 15; c++) begin
      tick();
      if (c < 9) for (int i = 0; i < NR; i++) set_req(i, 1'b0, AW'(16'h30 + i), '0);
      else clr_req();
      @(negedge clk);
      if (c < 9) chk("t2_grant", req_ready, DW'(1 << (c % 3)));
      if (c >= 5 && c < 14) begin
        chk("t2_rsp_valid", rsp_valid, DW'(1 << ((c - 5) % 3)));
        chk("t2_rsp_data", rsp_data, DW'(8'hA0 + (c - 5) % 3));
      end
      if (c == 14) chk("t2_rsp_end", rsp_valid, '0);
    end

    // Read after write to the same address
    do_reset();
    tick(); set_req(1, 1'b1, 16'h0020, 512'h55);
    @(negedge clk);
    chk("t3_wr_grant", req_ready, 3'b010);
    tick(); clr_req(); set_req(2, 1'b0, 16'h0020, '0);
    @(negedge clk);
    chk("t3_rd_grant", req_ready, 3'b100);
    chk("t3_wr_en", bram_wr_en, 1);
    chk("t3_wr_data", bram_wr_data, 512'h55);
    tick(); clr_req();
    @(negedge clk);
    chk("t3_rd_en", bram_rd_en, 1);
    for (int c = 3; c < 6; c++) begin
      tick(); @(negedge clk);
    end
    tick(); @(negedge clk);
    chk("t3_rsp_valid", rsp_valid, 3'b100);
    chk("t3_rsp_data", rsp_data, 512'h55);

    // Quiesce
    do_reset();
    preload(8'h40, 512'h11);
    preload(8'h41, 512'h22);
    for (int c = 0; c < 10; c++) begin
      tick();
      clr_req();
      quiesce = 1'b0;
      if (c < 2) set_req(0, 1'b0, AW'(16'h40 + c), '0);
      else if (c < 9) set_req(1, 1'b0, 16'h0042, '0);
      if (c >= 2 && c < 8) quiesce = 1'b1;
      if (c == 9) clr_req();
      @(negedge clk);
      if (c < 2) chk("t4_r0_grant", req_ready, 3'b001);
      if (c >= 2 && c < 8) chk("t4_quiesced", req_ready, '0);
      if (c == 5) begin
        chk("t4_rsp0_valid", rsp_valid, 3'b001);
        chk("t4_rsp0_data", rsp_data, 512'h11);
      end
      if (c == 6) begin
        chk("t4_rsp1_valid", rsp_valid, 3'b001);
        chk("t4_rsp1_data", rsp_data, 512'h22);
        chk("t4_idle_last_rsp", idle, 0);
      end
      if (c == 7) chk("t4_idle_after", idle, 1);
      if (c == 8) chk("t4_r1_grant", req_ready, 3'b010);
    end

    // Reset with a read in flight
    do_reset();
    preload(8'h10, 512'hAB);
    tick(); set_req(0, 1'b0, 16'h0010, '0);
    @(negedge clk);
    chk("t5_grant", req_ready, 3'b001);
    tick(); clr_req();
    @(negedge clk);
    chk("t5_rd_en", bram_rd_en, 1);
    for (int c = 2; c < 5; c++) begin
      tick(); rst_n = 1'b0;
      @(negedge clk);
      chk_reset_outputs();
    end
    tick(); rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("t5_no_rsp", rsp_valid, '0);
      tick();
    end

    // Single requester: back-to-back wr/rd/wr/rd
    for (int c = 0; c < 10; c++) begin
      tick();
      s_valid = 1'b0;
      if (c < 4) begin
        s_valid = 1'b1;
        s_wr    = (c % 2 == 0) ? 1'b1 : 1'b0;
        s_addr  = AW'(1 + c / 2);
        s_wdata = DW'(8'h71 + c / 2);
      end
      @(negedge clk);
      if (c < 4) chk("t6_ready", s_ready, 1);
      if (c == 6) begin
        chk("t6_rsp0_valid", s_rsp_valid, 1);
        chk("t6_rsp0_data", s_rsp_data, 512'h71);
      end
      if (c == 7) chk("t6_gap", s_rsp_valid, 0);
      if (c == 8) begin
        chk("t6_rsp1_valid", s_rsp_valid, 1);
        chk("t6_rsp1_data", s_rsp_data, 512'h72);
      end
      if (c == 9) chk("t6_idle", s_idle, 1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
